mem_dump_tx: RTL and testbench

- Memory-to-UART dump engine. It is the transmit-direction counterpart of the UART program loader.
- On a start request it reads WORD_COUNT consecutive 32-bit words from data memory through a read-only port and serialises each word as four 8N1 UART frames, least-significant byte first.
- It sits beside the data memory and shares the memory address mux while busy. Its tx output drives the board Tx pin.

---
 rtl/mem_dump_tx.sv | 191 +++++++++++++++++++
 tb/tb_mem_dump_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_tx.sv
// Memory-to-UART dump engine: reads WORD_COUNT words from data memory
// and sends each as four 8N1 frames, LSB byte first, on Tx_Serial.
// Ports: clk, rst (async active-low), start (async level),
//   rd_addr/rd_en/rd_data (read port), busy, send_done, word_cnt,
//   Tx_Serial (UART line, idles high).
module mem_dump_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WORD_COUNT   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] rd_addr,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        send_done,
  output logic [15:0] word_cnt,
  output logic        Tx_Serial
);

  if (WORD_COUNT < 1) begin : g_wc_chk
    $error("mem_dump_tx: WORD_COUNT must be >= 1");
  end
  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("mem_dump_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam int          TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] WC   = 32'(WORD_COUNT);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, STOP, NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   sh_q, sh_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic          rd_en_q, rd_en_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    sync_q;
  logic          start_rise;
  logic          tmr_last;

  // two sync flops plus one history flop for the edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 3'b000;
    else      sync_q <= {sync_q[1:0], start};
  end

  assign start_rise = sync_q[1] & ~sync_q[2];
  assign tmr_last   = (tmr_q == TMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      wcnt_q  <= '0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    rd_en_d = 1'b0;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          wcnt_d  = '0;
          addr_d  = BASE_ADDR;
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        sh_d    = rd_data;
        byte_d  = '0;
        tmr_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (tmr_last) begin
          tmr_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DATA: begin
        if (tmr_last) begin
          tmr_d = '0;
          // shifting on every bit leaves the next byte in sh_q[7:0]
          sh_d  = sh_q >> 1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      STOP: begin
        if (tmr_last) begin
          tmr_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = NEXT;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      NEXT: begin
        cnt_d  = cnt_q + 32'd1;
        wcnt_d = (cnt_q >= 32'h0000_FFFF) ? 16'hFFFF
                                          : cnt_q[15:0] + 16'd1;
        addr_d = addr_q + 32'd4;
        if (cnt_q + 32'd1 == WC) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr   = addr_q;
  assign rd_en     = rd_en_q;
  assign busy      = busy_q;
  assign send_done = done_q;
  assign word_cnt  = wcnt_q;
  assign Tx_Serial = tx_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: four instances with different parameters,
// a UART receiver task and a small memory model.
module tb_mem_dump_tx;

  localparam int IDLE_LIM = 400;

  logic        clk;
  logic        rst;
  logic        st[4];
  logic [31:0] rd_addr[4];
  logic        rd_en[4];
  logic [31:0] rd_data[4];
  logic        busy[4];
  logic        done[4];
  logic [15:0] wcnt[4];
  logic        tx[4];

  int          n_chk;
  int          n_fail;
  int          cyc;
  int          bcyc[4];
  int          brise[4];
  bit          pbusy[4];
  logic [31:0] alog[4][64];
  int          acnt[4];

  mem_dump_tx #(.CLKS_PER_BIT(4), .BASE_ADDR(32'h0), .WORD_COUNT(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .rd_addr(rd_addr[0]),
    .rd_en(rd_en[0]), .rd_data(rd_data[0]), .busy(busy[0]),
    .send_done(done[0]), .word_cnt(wcnt[0]), .Tx_Serial(tx[0]));

  mem_dump_tx #(.CLKS_PER_BIT(4), .BASE_ADDR(32'h10), .WORD_COUNT(3)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .rd_addr(rd_addr[1]),
    .rd_en(rd_en[1]), .rd_data(rd_data[1]), .busy(busy[1]),
    .send_done(done[1]), .word_cnt(wcnt[1]), .Tx_Serial(tx[1]));

  mem_dump_tx #(.CLKS_PER_BIT(4), .BASE_ADDR(32'hFFFF_FFFC),
                .WORD_COUNT(2)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .rd_addr(rd_addr[2]),
    .rd_en(rd_en[2]), .rd_data(rd_data[2]), .busy(busy[2]),
    .send_done(done[2]), .word_cnt(wcnt[2]), .Tx_Serial(tx[2]));

  mem_dump_tx #(.CLKS_PER_BIT(868), .BASE_ADDR(32'h100),
                .WORD_COUNT(1)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .rd_addr(rd_addr[3]),
    .rd_en(rd_en[3]), .rd_data(rd_data[3]), .busy(busy[3]),
    .send_done(done[3]), .word_cnt(wcnt[3]), .Tx_Serial(tx[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h1234_5678;
      32'h0000_0010: return 32'hAA55_AA55;
      32'h0000_0014: return 32'h0000_0000;
      32'h0000_0018: return 32'hFFFF_FFFF;
      32'hFFFF_FFFC: return 32'hCAFE_BABE;
      32'h0000_0100: return 32'h5A5A_5A55;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++)
      if (rd_en[k]) rd_data[k] <= memf(rd_addr[k]);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (busy[k]) bcyc[k] = bcyc[k] + 1;
      if (busy[k] && !pbusy[k]) brise[k] = cyc;
      pbusy[k] = busy[k];
      if (rd_en[k] && acnt[k] < 64) begin
        alog[k][acnt[k]] = rd_addr[k];
        acnt[k] = acnt[k] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Samples mid-bit on negedges; returns at the end of the stop bit.
  task automatic recv_byte(input int k, input int cpb,
                           output logic [7:0] b, output int idle,
                           output int sw, output int t0, output bit ok);
    int n;
    ok = 1'b1; idle = 0; sw = 0; b = 8'h00; t0 = 0;
    while (tx[k] !== 1'b0) begin
      if (idle >= IDLE_LIM) begin
        ok = 1'b0;
        return;
      end
      idle++;
      @(negedge clk);
    end
    t0 = cyc;
    n = 0;
    while (tx[k] === 1'b0 && n < cpb + cpb / 2) begin
      @(negedge clk); n++;
    end
    sw = n;
    for (int i = 0; i < 8; i++) begin
      while (n < cpb + cpb / 2 + i * cpb) begin
        @(negedge clk); n++;
      end
      b[i] = tx[k];
    end
    while (n < 9 * cpb + cpb / 2) begin
      @(negedge clk); n++;
    end
    if (tx[k] !== 1'b1) ok = 1'b0;
    while (n < 10 * cpb) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic recv_word(input int k, input int cpb,
                           input logic [31:0] w, input string tag,
                           output int idle0, output int t00);
    logic [7:0] b;
    int idle, sw, t0;
    bit ok;
    idle0 = 0; t00 = 0;
    for (int i = 0; i < 4; i++) begin
      recv_byte(k, cpb, b, idle, sw, t0, ok);
      chk($sformatf("%s_b%0d", tag, i), {55'd0, ok, b},
          {55'd0, 1'b1, w[8*i +: 8]});
      if (i == 0) begin
        idle0 = idle; t00 = t0;
      end else begin
        chk($sformatf("%s_gap%0d", tag, i), idle, 0);
      end
    end
  endtask

  task automatic wait_done(input int k, input string tag);
    int i;
    i = 0;
    while (done[k] !== 1'b1 && i < 2000) begin
      @(negedge clk); i++;
    end
    chk(tag, done[k], 1'b1);
  endtask

  int         a0, bc0, idl, t0a, t0b, sw0, d1;
  logic [7:0] bb;
  bit         okb;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int k = 0; k < 4; k++) begin
      st[k] = 1'b0; bcyc[k] = 0; brise[k] = 0; acnt[k] = 0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx[0], 1'b1);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_rden", rd_en[0], 1'b0);
    chk("rst_addr1", rd_addr[1], 32'h10);
    chk("rst_addr2", rd_addr[2], 32'hFFFF_FFFC);
    chk("rst_wcnt", wcnt[0], 16'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // basic single word
    a0 = acnt[0]; bc0 = bcyc[0];
    st[0] = 1'b1;
    recv_word(0, 4, 32'h1234_5678, "basic", idl, t0a);
    st[0] = 1'b0;
    wait_done(0, "basic_done");
    chk("basic_busy", busy[0], 1'b0);
    chk("basic_cycles", bcyc[0] - bc0, 163);
    chk("basic_lat", t0a - brise[0], 2);
    chk("basic_nrd", acnt[0] - a0, 1);
    chk("basic_addr", alog[0][a0], 32'h0);
    chk("basic_wcnt", wcnt[0], 16'd1);

    // multi-word with a dropped edge while busy and start held after
    a0 = acnt[1];
    fork
      begin
        recv_word(1, 4, 32'hAA55_AA55, "mw0", idl, t0a);
        chk("mw_wc0", wcnt[1], 16'd0);
        recv_word(1, 4, 32'h0000_0000, "mw1", idl, t0a);
        chk("mw_idle1", idl, 3);
        chk("mw_wc1", wcnt[1], 16'd1);
        recv_word(1, 4, 32'hFFFF_FFFF, "mw2", idl, t0a);
        chk("mw_idle2", idl, 3);
        chk("mw_wc2", wcnt[1], 16'd2);
      end
      begin
        st[1] = 1'b1;
        repeat (10) @(negedge clk);
        st[1] = 1'b0;
        repeat (30) @(negedge clk);
        st[1] = 1'b1;
      end
    join
    wait_done(1, "mw_done");
    chk("mw_wc3", wcnt[1], 16'd3);
    chk("mw_nrd", acnt[1] - a0, 3);
    chk("mw_a0", alog[1][a0], 32'h10);
    chk("mw_a1", alog[1][a0 + 1], 32'h14);
    chk("mw_a2", alog[1][a0 + 2], 32'h18);
    repeat (200) @(negedge clk);
    chk("held_busy", busy[1], 1'b0);
    chk("held_done", done[1], 1'b1);
    chk("held_nrd", acnt[1] - a0, 3);

    // fresh edge repeats the dump
    st[1] = 1'b0;
    repeat (5) @(negedge clk);
    st[1] = 1'b1;
    recv_word(1, 4, 32'hAA55_AA55, "rp0", idl, t0a);
    chk("rp_done_clr", done[1], 1'b0);
    chk("rp_busy", busy[1], 1'b1);
    recv_word(1, 4, 32'h0000_0000, "rp1", idl, t0a);
    recv_word(1, 4, 32'hFFFF_FFFF, "rp2", idl, t0a);
    wait_done(1, "rp_done");
    chk("rp_nrd", acnt[1] - a0, 6);
    st[1] = 1'b0;

    // async reset in the middle of byte 2 data bits
    repeat (5) @(negedge clk);
    st[1] = 1'b1;
    recv_byte(1, 4, bb, idl, sw0, t0a, okb);
    chk("ar_b0", {okb, bb}, {1'b1, 8'h55});
    recv_byte(1, 4, bb, idl, sw0, t0a, okb);
    chk("ar_b1", {okb, bb}, {1'b1, 8'hAA});
    repeat (9) @(negedge clk);
    chk("ar_pre_low", tx[1], 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("ar_tx", tx[1], 1'b1);
    chk("ar_busy", busy[1], 1'b0);
    chk("ar_wcnt", wcnt[1], 16'd0);
    chk("ar_done", done[1], 1'b0);
    st[1] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    a0 = acnt[1];
    st[1] = 1'b1;
    recv_word(1, 4, 32'hAA55_AA55, "ar_re", idl, t0a);
    chk("ar_re_addr", alog[1][a0], 32'h10);
    wait_done(1, "ar_re_done");
    st[1] = 1'b0;

    // address wrap
    a0 = acnt[2];
    st[2] = 1'b1;
    recv_word(2, 4, 32'hCAFE_BABE, "wr0", idl, t0a);
    recv_word(2, 4, 32'h1234_5678, "wr1", idl, t0a);
    chk("wr_idle1", idl, 3);
    wait_done(2, "wr_done");
    st[2] = 1'b0;
    chk("wr_nrd", acnt[2] - a0, 2);
    chk("wr_a0", alog[2][a0], 32'hFFFF_FFFC);
    chk("wr_a1", alog[2][a0 + 1], 32'h0);
    chk("wr_wcnt", wcnt[2], 16'd2);

    // real bit timing
    st[3] = 1'b1;
    recv_byte(3, 868, bb, idl, sw0, t0a, okb);
    chk("bt_b0", {okb, bb}, {1'b1, 8'h55});
    chk("bt_start_w", sw0, 868);
    recv_byte(3, 868, bb, idl, d1, t0b, okb);
    chk("bt_b1", {okb, bb}, {1'b1, 8'h5A});
    chk("bt_frame_w", t0b - t0a, 8680);
    for (int i = 2; i < 4; i++) begin
      recv_byte(3, 868, bb, idl, d1, t0b, okb);
      chk($sformatf("bt_b%0d", i), {okb, bb}, {1'b1, 8'h5A});
    end
    wait_done(3, "bt_done");
    st[3] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
